control_pipeline: RTL and testbench

- Consumer end of the ID-stage control decoder in the 5-stage RISC-V core.
- Carries the decoded 12-bit control bundle from ID through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles; squashes on EX redirects; tracks the halting ECALL; counts retired instructions.

---
 rtl/control_pipeline.sv | 177 +++++++++++++++++
 tb/tb_control_pipeline.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline.sv
// ---------------------------------------------------------------------------
// control_pipeline
//
// Carries the decoded 12-bit control bundle from the ID stage through the
// ID/EX, EX/MEM and MEM/WB registers of the 5-stage RISC-V core. It also:
//   - detects load-use hazards and inserts a bubble (stall),
//   - squashes the ID instruction on a taken EX redirect (flush),
//   - tracks the halting ECALL (x17 == 10) through to WB,
//   - counts instructions retired out of WB.
//
// Control bundle layout (id_ctrl / ex_ctrl / mem_ctrl):
//   [11] mem_write  [10] mem_read  [9] mem_to_reg  [8] alu_src
//   [7:6] alu_op    [5] write_enable [4] is_ecall  [3] is_jalr
//   [2] is_jal      [1] pc_to_reg    [0] branch
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_*                ID-stage instruction: valid, ctrl, register indices,
//                       operand-use flags, halt condition (x17 == 10)
//   ex_taken            EX resolved a taken branch / jump redirect
//   stall, flush        combinational hazard controls for PC and IF/ID
//   ex_*, mem_*         EX- and MEM-stage valid, ctrl and rd
//   wb_*                WB-stage valid, gated write/mux controls and rd
//   is_halted           sticky: the halting ECALL has left WB
//   retired             instructions retired (wraps at 2^CNT_WIDTH)
// ---------------------------------------------------------------------------
module control_pipeline #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [11:0]          id_ctrl,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic [4:0]           id_rd,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 id_halt_cond,
    input  logic                 ex_taken,
    output logic                 stall,
    output logic                 flush,
    output logic                 ex_valid,
    output logic [11:0]          ex_ctrl,
    output logic [4:0]           ex_rd,
    output logic                 mem_valid,
    output logic [11:0]          mem_ctrl,
    output logic [4:0]           mem_rd,
    output logic                 wb_valid,
    output logic                 wb_write_enable,
    output logic                 wb_mem_to_reg,
    output logic                 wb_pc_to_reg,
    output logic [4:0]           wb_rd,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] retired
);

    // Stage indices into the pipeline register arrays.
    localparam int EX         = 0;
    localparam int MEM        = 1;
    localparam int WB         = 2;
    localparam int NUM_STAGES = 3;

    localparam int CTRL_MEM_READ   = 10;
    localparam int CTRL_MEM_TO_REG = 9;
    localparam int CTRL_WRITE_EN   = 5;
    localparam int CTRL_IS_ECALL   = 4;
    localparam int CTRL_PC_TO_REG  = 1;

    logic        valid_reg [NUM_STAGES];
    logic [11:0] ctrl_reg  [NUM_STAGES];
    logic [4:0]  rd_reg    [NUM_STAGES];
    logic        halt_reg  [NUM_STAGES];

    logic                 halt_pending_reg;
    logic                 is_halted_reg;
    logic [CNT_WIDTH-1:0] retired_reg;

    logic hazard;
    logic id_load;
    logic ex_halt_next;

    // Load-use hazard: a load in EX whose destination is read by ID.
    // x0 never creates a dependency.
    always_comb begin
        hazard = valid_reg[EX] & ctrl_reg[EX][CTRL_MEM_READ] & (rd_reg[EX] != 5'd0)
               & ((id_use_rs1 & (id_rs1 == rd_reg[EX]))
                | (id_use_rs2 & (id_rs2 == rd_reg[EX])))
               & id_valid;
    end

    assign flush = valid_reg[EX] & ex_taken;
    // A redirect discards the ID instruction anyway, so flush wins and fetch
    // must not be held.
    assign stall = hazard & ~flush;

    // ID enters EX only when nothing squashes, delays or freezes it.
    assign id_load      = ~flush & ~stall & ~halt_pending_reg;
    assign ex_halt_next = id_load & id_valid & id_ctrl[CTRL_IS_ECALL] & id_halt_cond;

    // ID/EX register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg[EX] <= 1'b0;
            ctrl_reg[EX]  <= 12'd0;
            rd_reg[EX]    <= 5'd0;
            halt_reg[EX]  <= 1'b0;
        end else if (id_load) begin
            valid_reg[EX] <= id_valid;
            ctrl_reg[EX]  <= id_valid ? id_ctrl : 12'd0;
            rd_reg[EX]    <= id_rd;
            halt_reg[EX]  <= ex_halt_next;
        end else begin
            valid_reg[EX] <= 1'b0;
            ctrl_reg[EX]  <= 12'd0;
            rd_reg[EX]    <= 5'd0;
            halt_reg[EX]  <= 1'b0;
        end
    end

    // EX/MEM and MEM/WB registers advance unconditionally.
    generate
        for (genvar gi = MEM; gi < NUM_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    ctrl_reg[gi]  <= 12'd0;
                    rd_reg[gi]    <= 5'd0;
                    halt_reg[gi]  <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    ctrl_reg[gi]  <= ctrl_reg[gi-1];
                    rd_reg[gi]    <= rd_reg[gi-1];
                    halt_reg[gi]  <= halt_reg[gi-1];
                end
            end
        end
    endgenerate

    // Halt tracking and retirement counting. Once halted, anything still
    // reaching WB is not counted; the halting ECALL itself is, because
    // is_halted only rises on the edge it retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_pending_reg <= 1'b0;
            is_halted_reg    <= 1'b0;
            retired_reg      <= '0;
        end else begin
            if (ex_halt_next) begin
                halt_pending_reg <= 1'b1;
            end
            if (valid_reg[WB] & halt_reg[WB]) begin
                is_halted_reg <= 1'b1;
            end
            if (valid_reg[WB] & ~is_halted_reg) begin
                retired_reg <= retired_reg + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs. Ctrl is already zero in bubbles; gating keeps it so even if a
    // future change lets an invalid entry carry stale bits.
    assign ex_valid        = valid_reg[EX];
    assign ex_ctrl         = valid_reg[EX] ? ctrl_reg[EX] : 12'd0;
    assign ex_rd           = rd_reg[EX];
    assign mem_valid       = valid_reg[MEM];
    assign mem_ctrl        = valid_reg[MEM] ? ctrl_reg[MEM] : 12'd0;
    assign mem_rd          = rd_reg[MEM];
    assign wb_valid        = valid_reg[WB];
    assign wb_write_enable = valid_reg[WB] & ctrl_reg[WB][CTRL_WRITE_EN];
    assign wb_mem_to_reg   = valid_reg[WB] & ctrl_reg[WB][CTRL_MEM_TO_REG];
    assign wb_pc_to_reg    = valid_reg[WB] & ctrl_reg[WB][CTRL_PC_TO_REG];
    assign wb_rd           = rd_reg[WB];
    assign is_halted       = is_halted_reg;
    assign retired         = retired_reg;

endmodule

// File: tb/tb_control_pipeline.sv
// ---------------------------------------------------------------------------
// tb_control_pipeline
//
// Self-checking bench for control_pipeline: a table of per-cycle vectors for
// the basic flow, load-use and flush cases, hand-written sequences for halt,
// non-halting ECALL, squashed ECALL and mid-flight reset, then randomized
// stimulus compared against a time-indexed reference model.
// ---------------------------------------------------------------------------
module tb_control_pipeline;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [11:0] id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_halt_cond, ex_taken;
    logic        stall, flush;
    logic        ex_valid, mem_valid, wb_valid;
    logic [11:0] ex_ctrl, mem_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        wb_write_enable, wb_mem_to_reg, wb_pc_to_reg;
    logic        is_halted;
    logic [31:0] retired;

    int n_pass  = 0;
    int n_total = 0;

    control_pipeline #(.CNT_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_ctrl        (id_ctrl),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_halt_cond   (id_halt_cond),
        .ex_taken       (ex_taken),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ctrl        (ex_ctrl),
        .ex_rd          (ex_rd),
        .mem_valid      (mem_valid),
        .mem_ctrl       (mem_ctrl),
        .mem_rd         (mem_rd),
        .wb_valid       (wb_valid),
        .wb_write_enable(wb_write_enable),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_pc_to_reg   (wb_pc_to_reg),
        .wb_rd          (wb_rd),
        .is_halted      (is_halted),
        .retired        (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] C_ADD   = 12'h0A0;
    localparam logic [11:0] C_LW    = 12'h6E0;
    localparam logic [11:0] C_ECALL = 12'h010;
    localparam logic [11:0] C_BEQ   = 12'h001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_in(input int idv, input int ctrl, input int rs1, input int rs2,
                          input int rd, input int u1, input int u2, input int hc, input int tk);
        id_valid     = idv[0];
        id_ctrl      = ctrl[11:0];
        id_rs1       = rs1[4:0];
        id_rs2       = rs2[4:0];
        id_rd        = rd[4:0];
        id_use_rs1   = u1[0];
        id_use_rs2   = u2[0];
        id_halt_cond = hc[0];
        ex_taken     = tk[0];
    endtask

    // Called just after a negedge: one posedge passes with reset high.
    task automatic do_reset;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        idv;
        logic [11:0] ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic        u1;
        logic        tk;
        logic        e_stall;
        logic        e_flush;
        logic        e_exv;
        logic        e_wbv;
        logic [4:0]  e_wbrd;
        logic        e_we;
        logic [31:0] e_ret;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int idv, input int ctrl, input int rs1, input int rd,
                                input int u1, input int tk, input int st, input int fl,
                                input int exv, input int wbv, input int wbrd, input int we,
                                input int ret);
        vec_t v;
        v.idv = idv[0]; v.ctrl = ctrl[11:0]; v.rs1 = rs1[4:0]; v.rd = rd[4:0];
        v.u1 = u1[0]; v.tk = tk[0]; v.e_stall = st[0]; v.e_flush = fl[0];
        v.e_exv = exv[0]; v.e_wbv = wbv[0]; v.e_wbrd = wbrd[4:0]; v.e_we = we[0];
        v.e_ret = ret;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // hist holds what entered EX on each of the last three edges:
    // hist[2] is in EX now, hist[1] in MEM, hist[0] in WB.
    typedef struct {
        logic        v;
        logic [11:0] c;
        logic [4:0]  rd;
        logic        h;
    } ent_t;

    ent_t        hist[$];
    logic        m_pending, m_halted;
    logic [31:0] m_retired;

    function automatic ent_t empty_ent();
        ent_t e;
        e.v = 1'b0; e.c = 12'd0; e.rd = 5'd0; e.h = 1'b0;
        return e;
    endfunction

    task automatic model_reset;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(empty_ent());
        m_pending = 1'b0;
        m_halted  = 1'b0;
        m_retired = 32'd0;
    endtask

    task automatic model_check_and_step(input logic rst);
        ent_t ex, mem, wb, nxt;
        logic e_flush, e_haz, e_stall;
        ex  = hist[2];
        mem = hist[1];
        wb  = hist[0];
        e_flush = ex.v & ex_taken;
        e_haz   = ex.v && ex.c[10] && ex.rd != 0 && id_valid &&
                  ((id_use_rs1 && id_rs1 == ex.rd) || (id_use_rs2 && id_rs2 == ex.rd));
        e_stall = e_haz & ~e_flush;
        chk("rnd_stall",     64'(stall),           64'(e_stall));
        chk("rnd_flush",     64'(flush),           64'(e_flush));
        chk("rnd_ex_valid",  64'(ex_valid),        64'(ex.v));
        chk("rnd_ex_ctrl",   64'(ex_ctrl),         64'(ex.c));
        chk("rnd_ex_rd",     64'(ex_rd),           64'(ex.rd));
        chk("rnd_mem_valid", 64'(mem_valid),       64'(mem.v));
        chk("rnd_mem_ctrl",  64'(mem_ctrl),        64'(mem.c));
        chk("rnd_mem_rd",    64'(mem_rd),          64'(mem.rd));
        chk("rnd_wb_valid",  64'(wb_valid),        64'(wb.v));
        chk("rnd_wb_rd",     64'(wb_rd),           64'(wb.rd));
        chk("rnd_wb_we",     64'(wb_write_enable), 64'(wb.v & wb.c[5]));
        chk("rnd_wb_m2r",    64'(wb_mem_to_reg),   64'(wb.v & wb.c[9]));
        chk("rnd_wb_p2r",    64'(wb_pc_to_reg),    64'(wb.v & wb.c[1]));
        chk("rnd_is_halted", 64'(is_halted),       64'(m_halted));
        chk("rnd_retired",   64'(retired),         64'(m_retired));
        if (rst) begin
            model_reset();
        end else begin
            if (e_flush || e_stall || m_pending) begin
                nxt = empty_ent();
            end else begin
                nxt.v  = id_valid;
                nxt.c  = id_valid ? id_ctrl : 12'd0;
                nxt.rd = id_rd;
                nxt.h  = id_valid & id_ctrl[4] & id_halt_cond;
            end
            if (nxt.h) m_pending = 1'b1;
            if (wb.v && !m_halted) m_retired = m_retired + 32'd1;
            if (wb.v && wb.h) m_halted = 1'b1;
            void'(hist.pop_front());
            hist.push_back(nxt);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset state
        do_reset();
        #1;
        chk("rst_stall",     64'(stall),     64'd0);
        chk("rst_flush",     64'(flush),     64'd0);
        chk("rst_ex_valid",  64'(ex_valid),  64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_wb_valid",  64'(wb_valid),  64'd0);
        chk("rst_ex_ctrl",   64'(ex_ctrl),   64'd0);
        chk("rst_is_halted", 64'(is_halted), 64'd0);
        chk("rst_retired",   64'(retired),   64'd0);

        // Vector table: idv, ctrl, rs1, rd, use_rs1, taken | stall, flush,
        // ex_valid, wb_valid, wb_rd, wb_we, retired
        vecs[0]  = mk(1, C_ADD, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, C_ADD, 0, 2, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, C_ADD, 0, 3, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0,     0, 0, 0, 0,  0, 0, 1, 1, 1, 1, 0);
        vecs[4]  = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 1, 2, 1, 1);
        vecs[5]  = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 1, 3, 1, 2);
        vecs[6]  = mk(1, C_LW,  1, 5, 1, 0,  0, 0, 0, 0, 0, 0, 3);
        vecs[7]  = mk(1, C_ADD, 5, 6, 1, 0,  1, 0, 1, 0, 0, 0, 3);
        vecs[8]  = mk(1, C_ADD, 5, 6, 1, 0,  0, 0, 0, 0, 0, 0, 3);
        vecs[9]  = mk(0, 0,     0, 0, 0, 0,  0, 0, 1, 1, 5, 1, 3);
        vecs[10] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        vecs[11] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 1, 6, 1, 4);
        vecs[12] = mk(1, C_LW,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5);
        vecs[13] = mk(1, C_ADD, 0, 7, 1, 0,  0, 0, 1, 0, 0, 0, 5);
        vecs[14] = mk(0, 0,     0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 5);
        vecs[15] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 5);
        vecs[16] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 1, 7, 1, 6);
        vecs[17] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 7);
        vecs[18] = mk(1, C_LW,  0, 9, 0, 0,  0, 0, 0, 0, 0, 0, 7);
        vecs[19] = mk(1, C_ADD, 9, 10, 1, 1, 0, 1, 1, 0, 0, 0, 7);
        vecs[20] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 7);
        vecs[21] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 1, 9, 1, 7);
        vecs[22] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8);
        vecs[23] = mk(0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8);

        for (int i = 0; i < NVEC; i++) begin
            set_in(int'(vecs[i].idv), int'(vecs[i].ctrl), int'(vecs[i].rs1), 0,
                   int'(vecs[i].rd), int'(vecs[i].u1), 0, 0, int'(vecs[i].tk));
            #1;
            chk($sformatf("vec%0d_stall", i),    64'(stall),           64'(vecs[i].e_stall));
            chk($sformatf("vec%0d_flush", i),    64'(flush),           64'(vecs[i].e_flush));
            chk($sformatf("vec%0d_ex_valid", i), 64'(ex_valid),        64'(vecs[i].e_exv));
            chk($sformatf("vec%0d_wb_valid", i), 64'(wb_valid),        64'(vecs[i].e_wbv));
            chk($sformatf("vec%0d_wb_rd", i),    64'(wb_rd),           64'(vecs[i].e_wbrd));
            chk($sformatf("vec%0d_wb_we", i),    64'(wb_write_enable), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d_retired", i),  64'(retired),         64'(vecs[i].e_ret));
            @(negedge clk);
        end

        // Halting ECALL in ID at cycle 10
        do_reset();
        for (int c = 0; c < 25; c++) begin
            if (c < 10)       set_in(1, C_ADD, 0, 0, c + 1, 0, 0, 0, 0);
            else if (c == 10) set_in(1, C_ECALL, 17, 0, 0, 1, 0, 1, 0);
            else if (c < 20)  set_in(1, C_ADD, 0, 0, 20 + c, 0, 0, 0, 0);
            else              set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (c == 11) chk("halt_ex_ctrl_ecall", 64'(ex_ctrl), 64'(C_ECALL));
            if (c >= 12) chk($sformatf("halt_ex_bubble_c%0d", c), 64'(ex_valid), 64'd0);
            if (c == 13) begin
                chk("halt_wb_ecall",       64'(wb_valid),  64'd1);
                chk("halt_not_yet",        64'(is_halted), 64'd0);
                chk("halt_retired_before", 64'(retired),   64'd10);
            end
            if (c >= 14) begin
                chk($sformatf("halt_is_halted_c%0d", c), 64'(is_halted), 64'd1);
                chk($sformatf("halt_wb_empty_c%0d", c),  64'(wb_valid),  64'd0);
                chk($sformatf("halt_retired_c%0d", c),   64'(retired),   64'd11);
            end
            @(negedge clk);
        end

        // ECALL with halt condition false flows through
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c == 0)      set_in(1, C_ECALL, 17, 0, 0, 1, 0, 0, 0);
            else if (c == 5) set_in(1, C_ADD, 0, 0, 3, 0, 0, 0, 0);
            else             set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (c == 3) chk("ecall0_wb_valid", 64'(wb_valid), 64'd1);
            if (c == 4) chk("ecall0_retired",  64'(retired),  64'd1);
            if (c >= 1) chk($sformatf("ecall0_not_halted_c%0d", c), 64'(is_halted), 64'd0);
            if (c == 8) begin
                chk("ecall0_add_wb_valid", 64'(wb_valid), 64'd1);
                chk("ecall0_add_wb_rd",    64'(wb_rd),    64'd3);
            end
            if (c == 9) chk("ecall0_retired_after_add", 64'(retired), 64'd2);
            @(negedge clk);
        end

        // Halting ECALL squashed by a redirect
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c == 0)      set_in(1, C_BEQ, 0, 0, 0, 0, 0, 0, 0);
            else if (c == 1) set_in(1, C_ECALL, 17, 0, 0, 1, 0, 1, 1);
            else if (c == 2) set_in(1, C_ADD, 0, 0, 4, 0, 0, 0, 0);
            else             set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (c == 1) chk("sq_flush", 64'(flush), 64'd1);
            if (c == 2) chk("sq_ex_bubble", 64'(ex_valid), 64'd0);
            if (c == 3) begin
                chk("sq_ex_add_valid", 64'(ex_valid), 64'd1);
                chk("sq_ex_add_rd",    64'(ex_rd),    64'd4);
            end
            if (c == 6) chk("sq_retired", 64'(retired), 64'd2);
            if (c == 8) chk("sq_not_halted", 64'(is_halted), 64'd0);
            @(negedge clk);
        end

        // Reset with instructions in flight
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 6) set_in(1, C_ADD, 0, 0, c + 1, 0, 0, 0, 0);
            else       set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            reset = (c == 5);
            #1;
            if (c == 5) begin
                chk("mr_pre_ex_valid",  64'(ex_valid),  64'd1);
                chk("mr_pre_mem_valid", 64'(mem_valid), 64'd1);
                chk("mr_pre_wb_valid",  64'(wb_valid),  64'd1);
                chk("mr_pre_retired",   64'(retired),   64'd2);
            end
            if (c == 6) begin
                chk("mr_ex_valid",  64'(ex_valid),  64'd0);
                chk("mr_mem_valid", 64'(mem_valid), 64'd0);
                chk("mr_wb_valid",  64'(wb_valid),  64'd0);
                chk("mr_retired",   64'(retired),   64'd0);
                chk("mr_is_halted", 64'(is_halted), 64'd0);
            end
            @(negedge clk);
        end
        reset = 1'b0;

        // Randomized stimulus against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic rst;
            rst = ($urandom_range(0, 79) == 0);
            reset = rst;
            set_in(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 15) == 0),
                   int'($urandom_range(0, 5) == 0));
            #1;
            model_check_and_step(rst);
            @(negedge clk);
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
